// File: rtl/detect_event_logger_pkg.sv
// Shared constants, FIFO entry layout and saturating counter helper for the event logger.
// Latency: n/a (types and functions only).
// Backpressure: n/a. Optional macro EVT_STATE_CAPTURE_EN adds the detector state to each entry.
package evt_log_pkg;

    localparam int TS_W_DEF    = 16;
    localparam int DEPTH_DEF   = 8;
    localparam int CNT_W_DEF   = 8;
    localparam int DET_STATE_W = 3;

    // Entry layout at the default timestamp width; the top level builds the same
    // layout at its own TS_W when state capture is enabled.
    typedef struct packed {
        logic [TS_W_DEF-1:0]    ts;
        logic [DET_STATE_W-1:0] state;
    } entry_t;

    // Increment that sticks at the all-ones value of a w-bit counter (w <= 31).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (32'd1 << w) - 32'd1;
        return (v == max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/detect_event_logger_if.sv
// Read-side bundle of the event logger: head entry presentation, handshake and occupancy.
// Latency: wires only.
// Backpressure: consumer holds evt_ready low to leave the head entry in place.
// Optional macro EVT_STATE_CAPTURE_EN adds evt_state.
interface detect_event_logger_if #(
    parameter int TS_W  = 16,
    parameter int LVL_W = 4
);
    logic             evt_valid;
    logic             evt_ready;
    logic [TS_W-1:0]  evt_time;
    logic [LVL_W-1:0] evt_level;
`ifdef EVT_STATE_CAPTURE_EN
    logic [2:0]       evt_state;
`endif

    modport master (
        output evt_valid,
        output evt_time,
        output evt_level,
`ifdef EVT_STATE_CAPTURE_EN
        output evt_state,
`endif
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_time,
        input  evt_level,
`ifdef EVT_STATE_CAPTURE_EN
        input  evt_state,
`endif
        output evt_ready
    );
endinterface

// File: rtl/detect_event_logger_fifo.sv
// Synchronous show-ahead FIFO with push/pop, full/empty and occupancy outputs.
// Latency: a push is visible at dout on the cycle after the push edge; dout is the head combinationally.
// Backpressure: push while full is ignored unless a pop happens on the same edge; pop while empty is ignored.
module evt_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign dout    = mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer update; clear empties the FIFO ahead of any push or pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: the head is only meaningful while non-empty.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/detect_event_logger.sv
// Timestamps rising edges of the detector match output into a FIFO and keeps total/dropped counters.
// Latency: evt_valid is high the cycle after det_in is first sampled high; evt_time is show-ahead.
// Backpressure: events arriving while the FIFO is full (and not popping) are dropped and counted.
// Optional macro EVT_STATE_CAPTURE_EN stores det_state with each entry and drives evt.evt_state.
module detect_event_logger
    import evt_log_pkg::*;
#(
    parameter int TS_W  = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   det_in,
    input  logic [DET_STATE_W-1:0] det_state,
    input  logic                   clear,
    detect_event_logger_if.master  evt,
    output logic [CNT_W-1:0]       evt_count,
    output logic [CNT_W-1:0]       drop_count,
    output logic                   overflow
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

`ifdef EVT_STATE_CAPTURE_EN
    typedef struct packed {
        logic [TS_W-1:0]        ts;
        logic [DET_STATE_W-1:0] state;
    } log_entry_t;
    localparam int EW = $bits(log_entry_t);
`else
    localparam int EW = TS_W;
`endif

    logic [TS_W-1:0]  ts_cnt;
    logic             det_q;
    logic             event_edge;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             drop;
    logic [EW-1:0]    fifo_din;
    logic [EW-1:0]    fifo_dout;
    logic [LVL_W-1:0] fifo_level;

    assign event_edge = det_in && !det_q;
    assign pop        = !fifo_empty && evt.evt_ready && !clear;
    assign push       = event_edge && !clear && (!fifo_full || pop);
    assign drop       = event_edge && !clear && fifo_full && !pop;

`ifdef EVT_STATE_CAPTURE_EN
    log_entry_t head;
    assign fifo_din      = {ts_cnt, det_state};
    assign head          = log_entry_t'(fifo_dout);
    assign evt.evt_time  = fifo_empty ? '0 : head.ts;
    assign evt.evt_state = fifo_empty ? '0 : head.state;
`else
    logic unused_det_state;
    assign unused_det_state = ^det_state;
    assign fifo_din         = ts_cnt;
    assign evt.evt_time     = fifo_empty ? '0 : fifo_dout;
`endif

    assign evt.evt_valid = !fifo_empty;
    assign evt.evt_level = fifo_level;

    evt_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Free-running timestamp and edge-detect register; clear restarts both.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_cnt <= '0;
            det_q  <= 1'b0;
        end else if (clear) begin
            ts_cnt <= '0;
            det_q  <= 1'b0;
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
            det_q  <= det_in;
        end
    end

    // Saturating event/drop counters and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            evt_count  <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else if (clear) begin
            evt_count  <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (event_edge) evt_count <= CNT_W'(sat_inc(32'(evt_count), CNT_W));
            if (drop) begin
                drop_count <= CNT_W'(sat_inc(32'(drop_count), CNT_W));
                overflow   <= 1'b1;
            end
        end
    end

endmodule

// File: doc/detect_event_logger.md
Name: detect_event_logger

Overview:
- Downstream consumer of the sequence detector's 1-bit match output.
- Timestamps each match event against a free-running cycle counter.
- Buffers timestamps in a small FIFO, drained through a valid/ready read port, and keeps total and dropped-event counters for status readout.
- Sits between the detector and the system readout/CPU interface.

Parameters:
- TS_W, 16, timestamp counter width in bits; counter wraps modulo 2^TS_W.
- DEPTH, 8, FIFO depth in entries; power of two, minimum 2.
- CNT_W, 8, width of the total-event and dropped-event counters; both saturate.

Ports:
- clk  input  1  system clock; all state is rising-edge triggered.
- rst  input  1  reset, asynchronous assert, active-low (0 = reset).
- det_in  input  1  match output from the detector; level signal, may stay high for multiple cycles.
- det_state  input  3  detector FSM state; used only when the optional feature is enabled.
- clear  input  1  synchronous clear of counters, FIFO and sticky flags.
- evt_ready  input  1  consumer ready for the head entry.
- evt_valid  output  1  FIFO non-empty; head entry presented.
- evt_time  output  TS_W  timestamp of the head entry.
- evt_level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- evt_count  output  CNT_W  total events detected, including dropped ones.
- drop_count  output  CNT_W  events lost to a full FIFO.
- overflow  output  1  sticky flag; set on the first drop.

Behaviour:
- Reset (rst=0, async):
  - ts_cnt=0, det_q=0, FIFO empty.
  - evt_valid=0, evt_time=0, evt_level=0, evt_count=0, drop_count=0, overflow=0.
- Timestamp:
  - ts_cnt increments by 1 on every clk edge while rst=1 and clear=0.
  - Wraps from 2^TS_W-1 to 0 with no flag.
- Edge detection:
  - det_q registers det_in.
  - An event is det_in=1 && det_q=0 sampled at a clk edge.
  - A det_in held high counts as one event.
  - Back-to-back pulses (1,0,1) count as two events.
- Push:
  - On an event edge, the pre-increment ts_cnt is written to the FIFO.
  - evt_count increments, saturating at 2^CNT_W-1.
- Latency: evt_valid rises on the edge that captures the event; it is visible in the following cycle, i.e. 1 cycle after det_in is sampled high.
- Pop: on an edge where evt_valid && evt_ready, the head entry is removed. evt_time is combinational from the head entry (show-ahead).
- Full handling:
  - Event while full with no pop in the same cycle: entry dropped, drop_count increments (saturating), overflow set.
  - Event and pop in the same cycle while full: push accepted, no drop, level unchanged.
- Empty handling:
  - evt_ready while empty has no effect.
  - An event and evt_ready in the same cycle while empty: push only. The new entry is not popped that cycle (no fall-through).
- Level: evt_level = pushes minus pops; range 0..DEPTH.
- Clear (synchronous, priority over all other activity):
  - Resets everything to the reset values, including ts_cnt=0 and det_q=0.
  - An event edge coinciding with clear is discarded.
- Reset mid-operation: all state is lost immediately; no pending entry survives.
- det_state is ignored unless the optional feature is enabled.

Optional Feature:
- Macro: EVT_STATE_CAPTURE_EN.
- Defined:
  - Each FIFO entry also stores det_state sampled on the push edge.
  - An extra output evt_state [2:0] presents the head entry's captured state; it resets to 0.
- Undefined:
  - No evt_state port.
  - FIFO entry width is exactly TS_W.
  - det_state remains an input but is unused.

Decomposition:
- Package evt_log_pkg holds:
  - default constants TS_W_DEF=16, DEPTH_DEF=8, CNT_W_DEF=8, DET_STATE_W=3;
  - an entry struct typedef {ts, state};
  - a saturating-increment function for the counters.
- One sub-module, evt_fifo: a parameterised synchronous FIFO with show-ahead read, push/pop, full/empty and level outputs.
- Edge detect, timestamp counter, status counters and clear logic stay in the top level.

Test Plan:
- Reset release, det_in pulsed high for 1 cycle while ts_cnt=5 -> next cycle evt_valid=1, evt_time=5, evt_count=1, evt_level=1; evt_ready=1 for one cycle -> evt_valid=0.
- det_in held high 4 cycles from ts=10 -> exactly one entry, evt_time=10, evt_count=1.
- det_in pattern 1,0,1,0 starting ts=20 with evt_ready=0 -> two entries, times 20 and 22, evt_level=2; popped in that order.
- 9 separate events with evt_ready=0 at DEPTH=8 -> evt_level=8, drop_count=1, overflow=1, evt_count=9. Then an event together with a pop while full -> drop_count stays 1, level stays 8.
- clear asserted alongside an event edge with 3 entries buffered -> next cycle evt_level=0, evt_count=0, ts_cnt=0, overflow=0, evt_valid=0.
- TS_W=4: event when ts_cnt=15 and another when ts_cnt=1 after the wrap -> evt_time 15 then 1. With EVT_STATE_CAPTURE_EN and det_state=3'b100 at the push -> evt_state=3'b100.
